// File: rtl/prng_disp_pkg.sv
// prng_disp_pkg
// Shared constants for the PRNG seven-segment display slice.
//   SEG_BLANK   : all segments off (active-low).
//   SEG_A..G    : bit positions of each segment within the 7-bit bus {g,f,e,d,c,b,a}.
//   SEG_TABLE   : 16 packed 7-bit entries, entry k at bits [7k+6:7k], active-low.
//   seg_lookup  : nibble -> active-low segment pattern.
package prng_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry 0 sits in the least significant 7 bits.
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    return SEG_TABLE[{3'b000, nib} * 7 +: 7];
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg
// Purely combinational hex digit decoder.
//   i_nibble : 4-bit value to display.
//   o_seg    : segments {g,f,e,d,c,b,a}, active-low.
module hex_to_7seg
  import prng_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = seg_lookup(i_nibble);

endmodule

// File: rtl/prng_seg_display.sv
// prng_seg_display
// Shows the current PRNG value as hex on a multiplexed common-anode
// seven-segment display, lighting the decimal point for a fixed window
// after every value change.
//   clk     : system clock (same domain as the PRNG output register).
//   rst     : synchronous, active-high reset.
//   data_in : N-bit PRNG value.
//   an      : DIGITS digit enables, active-low, bit 0 = least significant nibble.
//   seg     : segments {g,f,e,d,c,b,a}, active-low.
//   dp      : decimal point, active-low.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading-zero digits
// above digit 0. Scan timing does not change with the macro.
module prng_seg_display
  import prng_disp_pkg::*;
#(
  parameter int N            = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int FLASH_CYCLES = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     data_in,
  output logic [N/4-1:0]   an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int DIGITS = N / 4;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int TW     = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(FLASH_CYCLES);

  logic [N-1:0]      r_shown;
  logic [TW-1:0]     r_timer;
  logic [SW-1:0]     r_scan;
  logic [IW-1:0]     r_idx;

  logic [N-1:0]      w_hi;
  logic [3:0]        w_nibble;
  logic [6:0]        w_seg_dec;
  logic [DIGITS-1:0] w_an_sel;
  logic              w_blank;

  // Shifting the active nibble down to bit 0 also leaves every higher
  // nibble above it, which is what the leading-zero test needs.
  assign w_hi     = r_shown >> {r_idx, 2'b00};
  assign w_nibble = w_hi[3:0];

  hex_to_7seg u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

  always_comb begin
    w_an_sel        = '1;
    w_an_sel[r_idx] = 1'b0;
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank = (r_idx != '0) && (w_hi == '0);
`else
  assign w_blank = 1'b0;
`endif

  // Capture and flash timer. A change always reloads the full window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shown <= '0;
      r_timer <= '0;
    end else if (data_in != r_shown) begin
      r_shown <= data_in;
      r_timer <= TIMER_LOAD;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  // Digit scan: each index holds for REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  // Registered outputs: one cycle behind index, shown value and timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= w_blank ? '1 : w_an_sel;
      seg <= w_blank ? SEG_BLANK : w_seg_dec;
      dp  <= !((r_idx == '0) && (r_timer != '0));
    end
  end

endmodule

// File: tb/tb_prng_seg_display.sv
// tb_prng_seg_display
// Bench for prng_seg_display with REFRESH_DIV=4, FLASH_CYCLES=10, N=8.
// The expected display is derived from the edge count since reset and
// the edge of the most recent value capture.
module tb_prng_seg_display;

  localparam int N      = 8;
  localparam int RD     = 4;
  localparam int FC     = 10;
  localparam int DIGITS = N / 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      data_in = '0;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              dp;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int           m_edge;      // non-reset edges since reset released
  logic [N-1:0] m_shown;     // value displayed before the next edge
  int           m_last_cap;  // edge at which the last capture happened

  logic [6:0] ref_seg [16];

  prng_seg_display #(
    .N            (N),
    .REFRESH_DIV  (RD),
    .FLASH_CYCLES (FC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Inputs change only on the falling edge.
  task automatic drive(input logic r, input logic [N-1:0] d);
    @(negedge clk);
    rst     = r;
    data_in = d;
  endtask

  // One active edge: predict, update the model, then compare.
  task automatic tick();
    logic [DIGITS-1:0] ea;
    logic [6:0]        es;
    logic              ed;
    logic [N-1:0]      hi;
    int                idx;
    int                age;
    @(posedge clk);
    if (rst) begin
      ea         = '1;
      es         = 7'h7F;
      ed         = 1'b1;
      m_edge     = 0;
      m_shown    = '0;
      m_last_cap = -1000;
    end else begin
      idx     = (m_edge / RD) % DIGITS;
      hi      = m_shown >> (4 * idx);
      ea      = '1;
      ea[idx] = 1'b0;
      es      = ref_seg[hi[3:0]];
      age     = m_edge - m_last_cap;
      ed      = !(idx == 0 && age >= 1 && age <= FC);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > 0 && hi == '0) begin
        ea = '1;
        es = 7'h7F;
      end
`endif
      if (data_in != m_shown) begin
        m_shown    = data_in;
        m_last_cap = m_edge;
      end
      m_edge++;
    end
    #1;
    check_val("an", 32'(an), 32'(ea));
    check_val("seg", 32'(seg), 32'(es));
    check_val("dp", 32'(dp), 32'(ed));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    ref_seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    m_edge     = 0;
    m_shown    = '0;
    m_last_cap = -1000;

    // Reset held for three edges, then the first post-reset edge.
    run(3);
    drive(1'b0, 8'h00);
    tick();
    check_val("first_an", 32'(an), 32'h2);
    check_val("first_seg", 32'(seg), 32'h40);

    // New value A5, then watch the flash window expire.
    drive(1'b0, 8'hA5);
    run(14);

    // Hold steady over three full scan periods.
    run(24);

    // Flash reload: second change 6 cycles after the first.
    drive(1'b0, 8'h3C);
    run(6);
    drive(1'b0, 8'h3D);
    run(16);

    // Reset during a digit-1 slot with the timer running.
    drive(1'b0, 8'h11);
    tick();
    for (int i = 0; i < 2 * RD && ((m_edge / RD) % DIGITS) != 1; i++) tick();
    check_val("mid_slot_is_digit1", 32'((m_edge / RD) % DIGITS), 32'd1);
    drive(1'b1, 8'h11);
    tick();
    drive(1'b0, 8'h11);
    run(12);

    // Leading zero value.
    drive(1'b0, 8'h07);
    run(12);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        drive(1'b1, data_in);
        run($urandom_range(1, 3));
        drive(1'b0, data_in);
      end else if ($urandom_range(0, 7) == 0) begin
        drive(1'b0, N'($urandom_range(0, 255)));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
